// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants, types and helpers for the data-memory responder.
//   WORD_W       : data word width (bits)
//   MEM_ADDR_W   : processor byte-address width (bits)
//   DEF_ADDR_W   : default RAM word-index width
//   wbuf_entry_t : one posted write {word index, data} at the default width
//   word_index() : byte address -> full word index (drops the byte offset)
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int MEM_ADDR_W = 16;
  localparam int DEF_ADDR_W = 10;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] idx;
    logic [WORD_W-1:0]     data;
  } wbuf_entry_t;

  // Returns every word-index bit of the byte address; callers decide how many
  // of them address the RAM and treat the rest as the out-of-range field.
  function automatic logic [MEM_ADDR_W-3:0] word_index(input logic [MEM_ADDR_W-1:0] addr);
    return addr[MEM_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/write_buffer.sv
// ---------------------------------------------------------------------------
// write_buffer
// Posted-write circular FIFO with per-slot valid bits and a combinational
// store-to-load forwarding lookup (youngest matching entry wins).
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_push, i_push_idx/data   : enqueue one entry (ignored when full)
//   i_pop                     : dequeue the oldest entry (ignored when empty)
//   o_pop_idx, o_pop_data     : oldest entry, presented for draining
//   i_look_idx                : word index to search for
//   o_hit, o_hit_data         : forwarding result
//   o_full, o_empty           : occupancy status, derived from the count register
// ---------------------------------------------------------------------------
module write_buffer
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_idx,
  input  logic [WORD_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_pop_idx,
  output logic [WORD_W-1:0] o_pop_data,
  input  logic [ADDR_W-1:0] i_look_idx,
  output logic              o_hit,
  output logic [WORD_W-1:0] o_hit_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_idx  [DEPTH];
  logic [WORD_W-1:0] r_data [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  assign o_pop_idx  = r_idx[r_rd_ptr];
  assign o_pop_data = r_data[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two. Push and pop can
  // never target the same slot: that would need count==0 (no pop) or
  // count==DEPTH (no push).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr]  <= 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_idx[r_wr_ptr]  <= i_push_idx;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] w_slot;
    w_slot     = '0;
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_rd_ptr + PTR_W'(k);
      if (r_valid[w_slot] && (r_idx[w_slot] == i_look_idx)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_slot];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the processor data-memory port: single-port word RAM,
// zero-latency reads with store-to-load forwarding, posted writes drained in
// the background whenever the processor is not reading.
// Ports:
//   Clock, nReset : clock, asynchronous active-low reset
//   MemAddr       : byte address (word aligned, below 4*2**ADDR_W)
//   MemRead       : read request this cycle
//   MemWrite      : write request this cycle (held by the processor while Stall)
//   WriteData     : store data
//   MemData       : combinational read data, 0 when not reading or on error
//   Stall         : write buffer full
//   WbEmpty       : no posted writes outstanding
//   AddrErr       : sticky, misaligned or out-of-range access seen
//   ProtoErr      : sticky, read and write requested together
// ---------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [MEM_ADDR_W-1:0] MemAddr,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [WORD_W-1:0]     WriteData,
  output logic [WORD_W-1:0]     MemData,
  output logic                  Stall,
  output logic                  WbEmpty,
  output logic                  AddrErr,
  output logic                  ProtoErr
);

  logic [WORD_W-1:0]     r_mem [2**ADDR_W];
  logic                  r_addr_err;
  logic                  r_proto_err;

  logic [MEM_ADDR_W-3:0] w_word;
  logic [ADDR_W-1:0]     w_idx;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_addr_ok;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_hit;
  logic [WORD_W-1:0]     w_fwd_data;
  logic [ADDR_W-1:0]     w_pop_idx;
  logic [WORD_W-1:0]     w_pop_data;

  assign w_word         = word_index(MemAddr);
  assign w_idx          = w_word[ADDR_W-1:0];
  assign w_misaligned   = (MemAddr[1:0] != 2'b00);
  assign w_out_of_range = ((w_word >> ADDR_W) != '0);
  assign w_addr_ok      = ~w_misaligned & ~w_out_of_range;

  // Stall comes from the count register, so a drain on a full cycle cannot
  // admit a write in that same cycle.
  assign w_accept = MemWrite & ~w_full & w_addr_ok;
  // The RAM has one port and the processor read owns it when present.
  assign w_drain  = ~w_empty & ~MemRead;

  write_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .i_clk       (Clock),
    .i_rst_n     (nReset),
    .i_push      (w_accept),
    .i_push_idx  (w_idx),
    .i_push_data (WriteData),
    .i_pop       (w_drain),
    .o_pop_idx   (w_pop_idx),
    .o_pop_data  (w_pop_data),
    .i_look_idx  (w_idx),
    .o_hit       (w_hit),
    .o_hit_data  (w_fwd_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // RAM contents survive reset; only the buffered writes are lost.
  always_ff @(posedge Clock) begin
    if (w_drain) begin
      r_mem[w_pop_idx] <= w_pop_data;
    end
  end

  always_comb begin
    MemData = '0;
    if (MemRead && w_addr_ok) begin
      MemData = w_hit ? w_fwd_data : r_mem[w_idx];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_addr_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if ((MemRead || MemWrite) && !w_addr_ok) begin
        r_addr_err <= 1'b1;
      end
      if (MemRead && MemWrite) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign Stall    = w_full;
  assign WbEmpty  = w_empty;
  assign AddrErr  = r_addr_err;
  assign ProtoErr = r_proto_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 16;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] MemData;
  logic        Stall;
  logic        WbEmpty;
  logic        AddrErr;
  logic        ProtoErr;

  data_mem_responder #(
    .ADDR_W     (ADDR_W),
    .WBUF_DEPTH (DEPTH)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .MemAddr   (MemAddr),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .MemData   (MemData),
    .Stall     (Stall),
    .WbEmpty   (WbEmpty),
    .AddrErr   (AddrErr),
    .ProtoErr  (ProtoErr)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: posted writes as an ordered queue, RAM as a plain array.
  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } ent_t;

  ent_t        wq[$];
  logic [31:0] ram_m [1024];
  bit          known [1024];
  bit          aerr_m = 1'b0;
  bit          perr_m = 1'b0;

  bit          cur_rd;
  bit          cur_wr;
  logic [15:0] cur_a;
  logic [31:0] cur_wd;
  bit          acc_d;

  function automatic bit addr_ok(input logic [15:0] a);
    return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 16'd0);
  endfunction

  function automatic bit exp_read(input logic [15:0] a, output logic [31:0] d);
    int unsigned w;
    w = int'(a) / 4;
    d = '0;
    for (int i = wq.size() - 1; i >= 0; i--) begin
      if (wq[i].idx == w) begin
        d = wq[i].data;
        return 1'b1;
      end
    end
    d = ram_m[w];
    return known[w];
  endfunction

  // Drive one request (just after a rising edge) and check outputs at the falling edge.
  task automatic dc(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] ed;
    bit          kn;
    cur_rd = rd; cur_wr = wr; cur_a = a; cur_wd = wd;
    MemRead = rd; MemWrite = wr; MemAddr = a; WriteData = wd;
    @(negedge Clock);
    chk("Stall",    32'(Stall),    32'(wq.size() == DEPTH));
    chk("WbEmpty",  32'(WbEmpty),  32'(wq.size() == 0));
    chk("AddrErr",  32'(AddrErr),  32'(aerr_m));
    chk("ProtoErr", 32'(ProtoErr), 32'(perr_m));
    if (!rd || !addr_ok(a)) begin
      chk("MemData_zero", MemData, 32'h0);
    end else begin
      kn = exp_read(a, ed);
      if (kn) chk("MemData", MemData, ed);
    end
  endtask

  // Advance the model across the rising edge using the request from dc.
  task automatic commit(output bit acc);
    bit   ok;
    bit   stall_m;
    bit   drain;
    ent_t e;
    ok      = addr_ok(cur_a);
    stall_m = (wq.size() == DEPTH);
    drain   = (wq.size() > 0) && !cur_rd;
    acc     = cur_wr && !stall_m && ok;
    @(posedge Clock);
    if (drain) begin
      e = wq.pop_front();
      ram_m[e.idx] = e.data;
      known[e.idx] = 1'b1;
    end
    if (acc) begin
      e.idx  = int'(cur_a) / 4;
      e.data = cur_wd;
      wq.push_back(e);
    end
    if ((cur_rd || cur_wr) && !ok) aerr_m = 1'b1;
    if (cur_rd && cur_wr) perr_m = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dc(1'b0, 1'b0, 16'h0, 32'h0);
      commit(acc_d);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [15:0] a;
    logic [31:0] d;
    int          r;

    nReset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemAddr = '0; WriteData = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_m[i] = '0;
      known[i] = 1'b0;
    end
    #12 nReset = 1'b1;
    @(posedge Clock); #1;

    // Reset state with a read of an uninitialised word.
    dc(1'b1, 1'b0, 16'h0000, 32'h0);
    chk("rst_WbEmpty", 32'(WbEmpty), 32'd1);
    chk("rst_Stall", 32'(Stall), 32'd0);
    chk("rst_AddrErr", 32'(AddrErr), 32'd0);
    commit(acc_d);

    // Give the test region known contents.
    for (int w = 0; w < NWORDS; w++) begin
      dc(1'b0, 1'b1, 16'(w * 4), $urandom);
      commit(acc_d);
    end
    idle(2);

    // Forwarding, then the same word from RAM after draining.
    dc(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF); commit(acc_d);
    dc(1'b1, 1'b0, 16'h0010, 32'h0);
    chk("fwd_data", MemData, 32'hDEADBEEF);
    chk("fwd_WbEmpty", 32'(WbEmpty), 32'd0);
    commit(acc_d);
    idle(1);
    dc(1'b1, 1'b0, 16'h0010, 32'h0);
    chk("ram_data", MemData, 32'hDEADBEEF);
    chk("ram_WbEmpty", 32'(WbEmpty), 32'd1);
    commit(acc_d);

    // Address errors: misaligned write dropped, out-of-range read returns 0.
    dc(1'b0, 1'b1, 16'h0003, 32'h12345678); commit(acc_d);
    dc(1'b1, 1'b0, 16'h1000, 32'h0);
    chk("oor_read", MemData, 32'h0);
    chk("aerr_set", 32'(AddrErr), 32'd1);
    chk("aerr_drop", 32'(WbEmpty), 32'd1);
    chk("perr_clear", 32'(ProtoErr), 32'd0);
    commit(acc_d);
    dc(1'b1, 1'b1, 16'h0018, 32'h00000018); commit(acc_d);
    dc(1'b0, 1'b0, 16'h0, 32'h0);
    chk("perr_set", 32'(ProtoErr), 32'd1);
    commit(acc_d);
    idle(1);

    // Fill the buffer with drain blocked, then a held fifth write.
    for (int i = 0; i < DEPTH; i++) begin
      dc(1'b1, 1'b1, 16'(i * 4), 32'hA000 + 32'(i));
      commit(acc_d);
    end
    dc(1'b1, 1'b1, 16'h0014, 32'h000000A5);
    chk("full_Stall", 32'(Stall), 32'd1);
    commit(acc);
    chk("full_held", 32'(acc), 32'd0);
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) begin
      dc(1'b0, 1'b1, 16'h0014, 32'h000000A5);
      commit(acc);
    end
    chk("stall_release", 32'(acc), 32'd1);
    idle(6);
    for (int i = 0; i < DEPTH; i++) begin
      dc(1'b1, 1'b0, 16'(i * 4), 32'h0);
      chk("fill_readback", MemData, 32'hA000 + 32'(i));
      commit(acc_d);
    end
    dc(1'b1, 1'b0, 16'h0014, 32'h0);
    chk("fifth_readback", MemData, 32'h000000A5);
    commit(acc_d);

    // Two writes to one word: youngest wins before and after draining.
    dc(1'b1, 1'b1, 16'h0020, 32'h1); commit(acc_d);
    dc(1'b1, 1'b1, 16'h0020, 32'h2); commit(acc_d);
    dc(1'b1, 1'b0, 16'h0020, 32'h0);
    chk("youngest_fwd", MemData, 32'h2);
    commit(acc_d);
    idle(3);
    dc(1'b1, 1'b0, 16'h0020, 32'h0);
    chk("youngest_ram", MemData, 32'h2);
    chk("youngest_empty", 32'(WbEmpty), 32'd1);
    commit(acc_d);

    // Asynchronous reset discards posted writes.
    for (int i = 0; i < 3; i++) begin
      dc(1'b1, 1'b1, 16'h0030 + 16'(i * 4), 32'hC0DE0000 + 32'(i));
      commit(acc_d);
    end
    #2;
    MemRead = 1'b0; MemWrite = 1'b0;
    nReset = 1'b0;
    #1;
    chk("arst_WbEmpty", 32'(WbEmpty), 32'd1);
    chk("arst_Stall", 32'(Stall), 32'd0);
    chk("arst_AddrErr", 32'(AddrErr), 32'd0);
    chk("arst_ProtoErr", 32'(ProtoErr), 32'd0);
    wq.delete();
    aerr_m = 1'b0;
    perr_m = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    @(posedge Clock); #1;
    for (int i = 0; i < 3; i++) begin
      dc(1'b1, 1'b0, 16'h0030 + 16'(i * 4), 32'h0);
      chk("arst_ram_kept", MemData, ram_m[12 + i]);
      commit(acc_d);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      a = 16'($urandom_range(0, NWORDS - 1) * 4);
      r = $urandom_range(0, 19);
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      else if (r == 1) a[15:12] = 4'($urandom_range(1, 15));
      d = $urandom;
      dc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      commit(acc_d);
    end
    idle(DEPTH + 1);
    for (int w = 0; w < NWORDS; w++) begin
      dc(1'b1, 1'b0, 16'(w * 4), 32'h0);
      commit(acc_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the processor data-memory port. Services MemRead/MemWrite requests issued by the MEM stage against an internal single-port word RAM. Reads return data combinationally in the same cycle. Writes are absorbed into a small posted write buffer that drains to RAM in the background, with store-to-load forwarding. Instantiated beside the processor top in the system wrapper.

Parameters:
ADDR_W, 10, word-index width; RAM holds 2**ADDR_W 32-bit words.
WBUF_DEPTH, 4, write-buffer entries; power of two, minimum 2.

Ports:
Clock  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
MemAddr  in  16  byte address from processor
MemRead  in  1  read request, this cycle
MemWrite  in  1  write request, this cycle
WriteData  in  32  store data
MemData  out  32  read data to processor
Stall  out  1  write buffer full; processor must hold the write request
WbEmpty  out  1  write buffer empty; no posted writes outstanding
AddrErr  out  1  sticky: misaligned or out-of-range access seen
ProtoErr  out  1  sticky: MemRead and MemWrite asserted together

Behaviour:
- Clock is the only clock. Reset is asynchronous and active-low on nReset.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, Stall=0, WbEmpty=1, AddrErr=0, ProtoErr=0.
- MemData has no reset value. It is combinational and reads 0 when MemRead=0.
- RAM contents are not reset. Posted writes pending when reset is asserted are discarded.
- Address decode:
  - word index = MemAddr[ADDR_W+1:2].
  - Misaligned: MemAddr[1:0] != 0.
  - Out of range: MemAddr[15:ADDR_W+2] != 0.
  - Either condition sets AddrErr on the clock edge.
  - An errored read returns 0. An errored write is dropped and never enters the buffer.
- Read, latency 0: MemData = data of the youngest buffer entry whose word index matches; otherwise RAM[index].
  - Forwarding compares every valid entry.
  - When several entries match, the most recently enqueued one wins.
- Write acceptance: accepted iff MemWrite & !Stall & address valid.
  - Accepted write: entry {index, WriteData} stored at wr_ptr; wr_ptr increments modulo WBUF_DEPTH.
  - Stall = (count == WBUF_DEPTH), registered from count.
  - While Stall=1 the processor holds MemAddr/WriteData/MemWrite stable. The write is accepted in the first cycle Stall=0.
- Drain: the RAM is single-port and a processor read has priority.
  - When count>0 and MemRead=0, the entry at rd_ptr is written to RAM on the edge; rd_ptr increments modulo WBUF_DEPTH.
  - When MemRead=1, drain is blocked that cycle.
- Count update: the same cycle may accept and drain. Then count is unchanged and the new entry lands in the slot freed-or-next (pointers are independent).
  - Accept only: count+1. Drain only: count-1.
  - count never exceeds WBUF_DEPTH and never underflows.
- Full boundary: acceptance is gated by Stall. Stall reflects count before the edge, so a drain on a full cycle does not admit a write that same cycle.
- Empty boundary: WbEmpty = (count==0). A read with an empty buffer comes from RAM only.
- ProtoErr: MemRead & MemWrite in the same cycle sets ProtoErr. The write is processed normally, and MemData shows read-path data for that address.
- Read-after-write: a store accepted at edge N is visible to a load at cycle N+1 via forwarding, before it drains.
- Sticky flags clear only on reset.

Decomposition:
- Package mem_pkg:
  - WORD_W=32 and MEM_ADDR_W=16 constants.
  - typedef wbuf_entry_t: struct {logic [ADDR_W-1:0] idx; logic [31:0] data;} (ADDR_W passed via package parameter default 10).
  - Function word_index(addr).
- One sub-module, write_buffer:
  - Circular FIFO with valid bits, push/pop, count, full/empty.
  - Combinational forwarding lookup (hit, data) with youngest-match priority.
- The top holds the RAM array, address checks, drain arbitration and error flags.

Test Plan:
- Reset, then read 0x0000 with MemRead=1 → no X on Stall/WbEmpty/flags; WbEmpty=1, Stall=0, AddrErr=0.
- Write 0x0010←0xDEADBEEF, next cycle read 0x0010 → MemData=0xDEADBEEF (forwarded, WbEmpty=0). After 1 idle cycle → WbEmpty=1, read still 0xDEADBEEF (from RAM).
- Four back-to-back writes 0x0000..0x000C with MemRead held 1 between (drain blocked), then a fifth write → Stall=1 and the fifth is held. One read-free cycle later Stall=0 and the fifth is accepted; all five read back correctly.
- Writes 0x0020←0x1, 0x0020←0x2, then read 0x0020 before drain → MemData=0x2 (youngest match). After drain → RAM holds 0x2.
- Write 0x0003 and read 0x1000 (ADDR_W=10) → AddrErr=1 sticky, read returns 0, count unchanged. MemRead&MemWrite together → ProtoErr=1.
- Three writes posted, assert nReset mid-cycle → WbEmpty=1 and Stall=0 immediately (async); RAM at those addresses not updated.
